// File: rtl/serial_adder_ctrl_if.sv
// Start/operand/result bundle for the bit-serial adder controller.
// The master side issues operands; the slave side returns busy/done and the result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder walks the operands LSB first,
// one bit per SHIFT edge, then publishes {cout,sum} with a one-cycle done pulse.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fa_s, fa_c;

   // Returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // Next-state, datapath and output decode.
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      s_sr_d   = s_sr_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      {fa_c, fa_s} = full_add(a_sr_q[0], b_sr_q[0], carry_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.cin;
               s_sr_d  = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            // The final bit is folded straight into the published result.
            if (cnt_q == LAST) begin
               sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
               cout_d  = fa_c;
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule
